wb_sram_slave: RTL and testbench

- Single-port Wishbone B4 memory slave. Connects directly to one slave port (s0..s4) of the system interconnects.
- Consumes the address-decoded transfers the interconnect produces.
- Supports classic cycles and registered-feedback incrementing bursts (CTI/BTE), so an interconnected master can sustain one beat per clock.
- Optional read-only mode makes it usable as a boot ROM.

---
 rtl/wb_sys_pkg.sv | 28 ++
 rtl/wb_if.sv | 27 ++
 rtl/wb_burst_addr_next.sv | 23 ++
 rtl/wb_sram_slave.sv | 117 +++++++++++
 tb/tb_wb_sram_slave.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/wb_sys_pkg.sv
// rtl/wb_sys_pkg.sv - shared Wishbone B4 cycle/burst types and helpers
package wb_sys_pkg;

    typedef enum logic [2:0] {
        CLASSIC = 3'b000,
        CONST   = 3'b001,
        INCR    = 3'b010,
        EOB     = 3'b111
    } cti_e;

    typedef enum logic [1:0] {
        LINEAR = 2'b00,
        WRAP4  = 2'b01,
        WRAP8  = 2'b10,
        WRAP16 = 2'b11
    } bte_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SINGLE = 2'b01,
        ST_BURST  = 2'b10
    } sram_state_e;

    function automatic int byte_off_bits(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/wb_if.sv
// rtl/wb_if.sv - Wishbone B4 bus bundle with registered-feedback burst tags
interface wb_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0]   adr;
    logic [2:0]      cti;
    logic [1:0]      bte;
    logic [DW-1:0]   dat_w;
    logic [DW-1:0]   dat_r;
    logic [DW/8-1:0] sel;
    logic            cyc;
    logic            stb;
    logic            we;
    logic            ack;
    logic            err;

    modport slave (
        input  adr, cti, bte, dat_w, sel, cyc, stb, we,
        output dat_r, ack, err
    );

    modport master (
        output adr, cti, bte, dat_w, sel, cyc, stb, we,
        input  dat_r, ack, err
    );
endinterface

// File: rtl/wb_burst_addr_next.sv
// rtl/wb_burst_addr_next.sv - next word index of a Wishbone incrementing burst
module wb_burst_addr_next
    import wb_sys_pkg::*;
#(
    parameter int IDX_BITS = 10
) (
    input  logic [IDX_BITS-1:0] i_idx,
    input  bte_e                i_bte,
    output logic [IDX_BITS-1:0] o_next
);

    // Wrapped bursts only advance the low bits; upper bits stay pinned.
    always_comb begin
        o_next = i_idx;
        case (i_bte)
            WRAP4:   o_next[1:0] = i_idx[1:0] + 2'd1;
            WRAP8:   o_next[2:0] = i_idx[2:0] + 3'd1;
            WRAP16:  o_next[3:0] = i_idx[3:0] + 4'd1;
            default: o_next      = i_idx + IDX_BITS'(1);
        endcase
    end

endmodule

// File: rtl/wb_sram_slave.sv
// rtl/wb_sram_slave.sv - Wishbone B4 SRAM/ROM slave with classic and incrementing bursts
module wb_sram_slave
    import wb_sys_pkg::*;
#(
    parameter int WB_ADDR_WIDTH = 32,
    parameter int WB_DATA_WIDTH = 32,
    parameter int MEM_ADDR_BITS = 10,
    parameter int READ_ONLY     = 0
) (
    input  logic clk,
    input  logic rstn,
    wb_if.slave  s
);

    localparam int BO    = byte_off_bits(WB_DATA_WIDTH);
    localparam int DEPTH = 1 << MEM_ADDR_BITS;
    localparam int NB    = WB_DATA_WIDTH / 8;
    localparam bit RO    = (READ_ONLY != 0);

    sram_state_e              r_state;
    sram_state_e              w_state_nxt;
    logic [WB_DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [WB_DATA_WIDTH-1:0] r_dat_r;
    logic [MEM_ADDR_BITS-1:0] r_cur_idx;
    logic [MEM_ADDR_BITS-1:0] w_idx;
    logic [MEM_ADDR_BITS-1:0] w_next_idx;
    logic                     r_ack;
    logic                     r_err;
    logic                     w_req;
    logic                     w_done;
    logic                     w_more;
    logic                     w_wr;
    logic                     w_unused;

    assign w_idx    = s.adr[BO+MEM_ADDR_BITS-1:BO];
    assign w_req    = s.cyc & s.stb;
    assign w_done   = w_req & (r_ack | r_err);
    assign w_more   = (s.cti == INCR);
    assign w_wr     = w_done & r_ack & s.we & ~RO;
    assign w_unused = ^s.adr;

    wb_burst_addr_next #(.IDX_BITS(MEM_ADDR_BITS)) u_next (
        .i_idx  (r_cur_idx),
        .i_bte  (bte_e'(s.bte)),
        .o_next (w_next_idx)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_req) w_state_nxt = w_more ? ST_BURST : ST_SINGLE;
            ST_SINGLE: if (!s.cyc || w_done) w_state_nxt = ST_IDLE;
            ST_BURST:  if (!s.cyc || (w_done && !w_more)) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        s.ack   = r_ack & w_req;
        s.err   = r_err & w_req;
        s.dat_r = r_dat_r;
    end

    // Read data is prefetched one beat ahead so ACK can stay high every cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ack     <= 1'b0;
            r_err     <= 1'b0;
            r_dat_r   <= '0;
            r_cur_idx <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_cur_idx <= w_idx;
                        r_dat_r   <= r_mem[w_idx];
                        if (s.we && RO) r_err <= 1'b1;
                        else            r_ack <= 1'b1;
                    end
                end
                ST_SINGLE: begin
                    if (!s.cyc || w_done) begin
                        r_ack <= 1'b0;
                        r_err <= 1'b0;
                    end
                end
                ST_BURST: begin
                    if (!s.cyc || (w_done && !w_more)) begin
                        r_ack <= 1'b0;
                        r_err <= 1'b0;
                    end else if (w_done) begin
                        r_cur_idx <= w_next_idx;
                        r_dat_r   <= r_mem[w_next_idx];
                    end
                end
                default: begin
                    r_ack <= 1'b0;
                    r_err <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            for (int b = 0; b < NB; b++) begin
                if (s.sel[b]) r_mem[r_cur_idx][8*b +: 8] <= s.dat_w[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_wb_sram_slave.sv
// tb/tb_wb_sram_slave.sv - directed scoreboard bench for wb_sram_slave
module tb_wb_sram_slave;

    logic clk;
    logic rstn;
    int   checks;
    int   failures;

    logic [31:0] model [0:1023];
    logic [31:0] exp_q [$];

    wb_if #(.AW(32), .DW(32)) bus ();
    wb_if #(.AW(32), .DW(32)) bus_ro ();

    wb_sram_slave #(.READ_ONLY(0)) u_dut (
        .clk  (clk),
        .rstn (rstn),
        .s    (bus)
    );

    wb_sram_slave #(.READ_ONLY(1)) u_rom (
        .clk  (clk),
        .rstn (rstn),
        .s    (bus_ro)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    function automatic int nxt(input int idx, input logic [1:0] bte);
        int m;
        case (bte)
            2'b00:   return (idx + 1) % 1024;
            2'b01:   m = 3;
            2'b10:   m = 7;
            default: m = 15;
        endcase
        return (idx & ~m) | ((idx + 1) & m);
    endfunction

    task automatic model_write(input int idx, input logic [31:0] d, input logic [3:0] sel);
        for (int b = 0; b < 4; b++)
            if (sel[b]) model[idx][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic bus_idle();
        bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
        bus.cti = 3'b000; bus.bte = 2'b00;
    endtask

    task automatic classic(input bit wr, input logic [31:0] adr, input logic [31:0] d,
                           input logic [3:0] sel);
        int idx;
        idx = int'((adr >> 2) & 32'h3FF);
        bus.adr = adr; bus.we = wr; bus.dat_w = d; bus.sel = sel;
        bus.cti = 3'b000; bus.bte = 2'b00; bus.cyc = 1'b1; bus.stb = 1'b1;
        #1 chk("classic_early_ack", 32'(bus.ack), 0);
        if (wr) model_write(idx, d, sel);
        else    exp_q.push_back(model[idx]);
        step();
        chk("classic_ack", 32'(bus.ack), 1);
        chk("classic_err", 32'(bus.err), 0);
        if (!wr && bus.ack) chk("classic_data", bus.dat_r, exp_q.pop_front());
        step();
        chk("classic_ack_drop", 32'(bus.ack), 0);
        bus_idle();
    endtask

    task automatic burst(input bit wr, input int start_idx, input int n, input logic [1:0] bte,
                         input logic [31:0] base, input int gap_at, input int abort_at);
        int idx;
        idx = start_idx;
        bus.adr = 32'(start_idx * 4); bus.we = wr; bus.bte = bte; bus.sel = 4'hF;
        bus.cti = 3'b010; bus.dat_w = base; bus.cyc = 1'b1; bus.stb = 1'b1;
        for (int i = 0; i < n; i++) begin
            step();
            if (i == abort_at) begin
                bus_idle();
                return;
            end
            if (i == gap_at) begin
                bus.stb = 1'b0;
                repeat (2) begin
                    step();
                    chk("gap_ack", 32'(bus.ack), 0);
                end
                bus.stb = 1'b1;
                #1;
            end
            bus.cti = (i == n - 1) ? 3'b111 : 3'b010;
            bus.dat_w = base + 32'(i);
            if (wr) model_write(idx, base + 32'(i), 4'hF);
            else    exp_q.push_back(model[idx]);
            chk("burst_ack", 32'(bus.ack), 1);
            if (!wr && bus.ack) chk("burst_data", bus.dat_r, exp_q.pop_front());
            idx = nxt(idx, bte);
        end
        step();
        chk("burst_end_ack", 32'(bus.ack), 0);
        bus_idle();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        bus.adr = '0; bus.dat_w = '0; bus.sel = '0; bus_idle();
        bus_ro.adr = '0; bus_ro.dat_w = '0; bus_ro.sel = '0; bus_ro.cti = '0; bus_ro.bte = '0;
        bus_ro.cyc = 1'b0; bus_ro.stb = 1'b0; bus_ro.we = 1'b0;

        rstn = 1'b0;
        bus.cyc = 1'b1; bus.stb = 1'b1;
        step(); step();
        chk("reset_ack", 32'(bus.ack), 0);
        chk("reset_err", 32'(bus.err), 0);
        chk("reset_dat", bus.dat_r, 0);
        bus_idle();
        rstn = 1'b1;
        step();

        burst(1'b1, 'h3F0, 32, 2'b00, 32'hA500_0000, -1, -1);

        classic(1'b1, 32'h40, 32'hDEAD_BEEF, 4'hF);
        classic(1'b0, 32'h40, 32'h0, 4'hF);
        classic(1'b1, 32'h40, 32'h00AA_0000, 4'b0100);
        classic(1'b0, 32'h40, 32'h0, 4'hF);

        burst(1'b0, 'h3FE, 4, 2'b00, 32'h0, -1, -1);

        burst(1'b1, 6, 4, 2'b01, 32'h1, -1, -1);
        for (int w = 4; w <= 8; w++) classic(1'b0, 32'(w * 4), 32'h0, 4'hF);

        burst(1'b0, 2, 5, 2'b00, 32'h0, 2, -1);

        burst(1'b0, 'h3F4, 4, 2'b00, 32'h0, -1, 2);
        exp_q.delete();
        step();
        classic(1'b0, 32'h40, 32'h0, 4'hF);

        burst(1'b0, 'h3FD, 6, 2'b10, 32'h0, -1, -1);
        burst(1'b0, 'h00E, 4, 2'b11, 32'h0, -1, -1);

        bus_ro.adr = 32'h80; bus_ro.we = 1'b1; bus_ro.dat_w = 32'hCAFE_F00D; bus_ro.sel = 4'hF;
        bus_ro.cyc = 1'b1; bus_ro.stb = 1'b1;
        step();
        chk("ro_err", 32'(bus_ro.err), 1);
        chk("ro_ack", 32'(bus_ro.ack), 0);
        step();
        chk("ro_err_drop", 32'(bus_ro.err), 0);
        bus_ro.cyc = 1'b0; bus_ro.stb = 1'b0; bus_ro.we = 1'b0;
        step();
        bus_ro.cyc = 1'b1; bus_ro.stb = 1'b1;
        step();
        chk("ro_read_ack", 32'(bus_ro.ack), 1);
        chk("ro_unchanged", 32'(bus_ro.dat_r !== 32'hCAFE_F00D), 1);
        bus_ro.cyc = 1'b0; bus_ro.stb = 1'b0;
        step();

        bus.adr = 32'h40; bus.we = 1'b0; bus.cti = 3'b010; bus.bte = 2'b00; bus.sel = 4'hF;
        bus.cyc = 1'b1; bus.stb = 1'b1;
        step();
        chk("rst_pre_ack0", 32'(bus.ack), 1);
        step();
        chk("rst_pre_ack1", 32'(bus.ack), 1);
        #2 rstn = 1'b0;
        #1;
        chk("rst_mid_ack", 32'(bus.ack), 0);
        chk("rst_mid_dat", bus.dat_r, 0);
        bus_idle();
        step();
        rstn = 1'b1;
        step();
        classic(1'b0, 32'h40, 32'h0, 4'hF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
